// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory / write-back slice.
// Imported by the stage top and its write-back select mux.
package mips_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/wb_select_mux.sv
// Register-file write-back source select: ALU result or memory data.
// Purely combinational; the stage registers the result.
module wb_select_mux
  import mips_pkg::*;
(
  input  logic        sel,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_result,
  output logic [31:0] wb_data
);

  assign wb_data = (sel == WB_MEM) ? mem_result : alu_result;

endmodule

// File: rtl/mem_writeback_stage.sv
// MEM/WB stage: issues one memory access at a time, stalls upstream while
// waiting, aborts on timeout, and registers the write-back and retire count.
module mem_writeback_stage
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EXMEMAluOutput,
  input  logic [31:0] EXMEMstoreData,
  input  logic [4:0]  EXMEMwritereg,
  input  logic        EXMEMWriteRegEnable,
  input  logic        EXMEMReadMemoryEnable,
  input  logic        EXMEMWriteMemoryEnable,
  input  logic        EXMEMwritebackRegCtrl,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] writeData,
  output logic [4:0]  MemWBwritereg,
  output logic        WriteRegEnable,
  output logic        mem_stall,
  output logic        mem_error,
  output logic [31:0] retire_count
);

  mem_state_t  state;
  logic [31:0] tmo_cnt;
  logic [31:0] lat_alu;
  logic [4:0]  lat_reg;
  logic        lat_wre;
  logic        lat_store;
  logic        lat_ctrl;

  logic        in_access;
  logic        mem_op;
  logic        wb_sel;
  logic [31:0] wb_alu;
  logic [31:0] wb_data;

  assign in_access = (state == ACCESS);
  assign mem_op    = EXMEMReadMemoryEnable | EXMEMWriteMemoryEnable;
  assign wb_sel    = in_access ? lat_ctrl : EXMEMwritebackRegCtrl;
  assign wb_alu    = in_access ? lat_alu : EXMEMAluOutput;

  wb_select_mux u_wb_mux (
    .sel        (wb_sel),
    .alu_result (wb_alu),
    .mem_result (mem_rdata),
    .wb_data    (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      lat_alu        <= '0;
      lat_reg        <= '0;
      lat_wre        <= 1'b0;
      lat_store      <= 1'b0;
      lat_ctrl       <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      writeData      <= '0;
      MemWBwritereg  <= '0;
      WriteRegEnable <= 1'b0;
      mem_stall      <= 1'b0;
      mem_error      <= 1'b0;
      retire_count   <= '0;
    end else begin
      WriteRegEnable <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Store takes priority when both enables are set.
            lat_alu   <= EXMEMAluOutput;
            lat_reg   <= EXMEMwritereg;
            lat_wre   <= EXMEMWriteRegEnable;
            lat_store <= EXMEMWriteMemoryEnable;
            lat_ctrl  <= EXMEMwritebackRegCtrl;
            mem_addr  <= EXMEMAluOutput;
            mem_wdata <= EXMEMstoreData;
            mem_req   <= 1'b1;
            mem_we    <= EXMEMWriteMemoryEnable;
            mem_stall <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ACCESS;
          end else begin
            writeData     <= wb_data;
            MemWBwritereg <= EXMEMwritereg;
            if (EXMEMWriteRegEnable) begin
              WriteRegEnable <= (EXMEMwritereg != 5'd0);
              retire_count   <= retire_count + 32'd1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            writeData      <= wb_data;
            MemWBwritereg  <= lat_reg;
            WriteRegEnable <= lat_wre & ~lat_store &
                              (lat_reg != 5'd0);
            retire_count   <= retire_count + 32'd1;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_stall      <= 1'b0;
            state          <= IDLE;
          end else if (tmo_cnt == 32'(MEM_TIMEOUT - 1)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_stall <= 1'b0;
            mem_error <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
